ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_pkg.sv | 18 +
 rtl/ram_fifo_ptr.sv | 33 +++
 rtl/ram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_pkg
//  Description : Shared sizing constants for the RAM-backed FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    // Data width shared by the controller and the external RAM
    localparam int DATA_W = 8;
    // RAM address width and the resulting FIFO depth
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    // Pointers carry one extra wrap bit to tell full from empty
    localparam int PTR_W  = ADDR_W + 1;

endpackage : ram_fifo_pkg
`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ptr
//  Description : Free-running incrementing pointer with enable; wraps
//                naturally modulo 2**WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = PTR_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] r_ptr;

    // Advance by one on each enabled edge; reset returns to zero at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule : ram_fifo_ptr
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : FIFO controller driving an external single-cycle-latency
//                RAM. Holds only pointers, status and the read-data stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int DATA_W    = ram_fifo_pkg::DATA_W,
    parameter int ADDR_W    = ram_fifo_pkg::ADDR_W,
    parameter int AFULL_LVL = 14
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              re,
    output logic [ADDR_W-1:0] re_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int c_PTR_W = ADDR_W + 1;

    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_PTR_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;

    logic               r_dout_valid;
    logic [DATA_W-1:0]  r_dout_hold;
    logic               r_overflow;
    logic               r_underflow;

    // Status comes straight from the registered pointers
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]) &&
                     (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]);
    assign w_count = w_wr_ptr - w_rd_ptr;

    // Requests are judged independently; reset suppresses both so the RAM
    // sees no strobe while the controller is being cleared
    assign w_push_ok = push & ~w_full  & ~rst;
    assign w_pop_ok  = pop  & ~w_empty & ~rst;

    ram_fifo_ptr #(.WIDTH(c_PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_push_ok),
        .ptr (w_wr_ptr)
    );

    ram_fifo_ptr #(.WIDTH(c_PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_pop_ok),
        .ptr (w_rd_ptr)
    );

    // Read-data stage: valid follows an accepted pop by one cycle, the last
    // RAM word is captured so dout holds between pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout_hold  <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_ok;
            if (r_dout_valid) begin
                r_dout_hold <= ram_dout;
            end
            r_overflow   <= push & w_full;
            r_underflow  <= pop  & w_empty;
        end
    end

    assign we          = w_push_ok;
    assign wr_addr     = w_wr_ptr[ADDR_W-1:0];
    assign ram_din     = din;
    assign re          = w_pop_ok;
    assign re_addr     = w_rd_ptr[ADDR_W-1:0];
    assign dout        = r_dout_valid ? ram_dout : r_dout_hold;
    assign dout_valid  = r_dout_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = w_count;
    assign almost_full = (w_count >= c_PTR_W'(AFULL_LVL));
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule : ram_fifo_ctrl
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl with a behavioural
//                external RAM and a scoreboard on the popped data stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       we;
    logic [3:0] wr_addr;
    logic [7:0] ram_din;
    logic       re;
    logic [3:0] re_addr;
    logic [7:0] ram_dout;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [16];

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .din         (din),
        .pop         (pop),
        .we          (we),
        .wr_addr     (wr_addr),
        .ram_din     (ram_din),
        .re          (re),
        .re_addr     (re_addr),
        .ram_dout    (ram_dout),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural external RAM with one cycle of read latency
    always @(posedge clk) begin
        if (we) mem[wr_addr] <= ram_din;
        if (re) ram_dout <= mem[re_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented word must match the oldest expected
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL dout_unexpected: got %0h expected none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_errors++;
                    $display("FAIL dout: got %0h expected %0h", dout, e);
                end
            end
        end
    end

    // Apply one cycle of stimulus at the falling edge, settle before checks
    task automatic drive(input logic p, input logic [7:0] d, input logic q);
        @(negedge clk);
        push = p;
        din  = d;
        pop  = q;
        #1;
    endtask

    task automatic do_push(input logic [7:0] d);
        drive(1'b1, d, 1'b0);
        chk("push_we", we, 1);
        chk("push_wr_addr", wr_addr, n_wr % 16);
        n_wr++;
    endtask

    task automatic do_pop(input logic [7:0] e);
        drive(1'b0, 8'h00, 1'b1);
        chk("pop_re", re, 1);
        chk("pop_re_addr", re_addr, n_rd % 16);
        exp_q.push_back(e);
        n_rd++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; push = 1'b0; din = 8'h00; pop = 1'b0;
        // Requests during reset must be ignored
        drive(1'b1, 8'h55, 1'b1);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Fill with 10..25
        for (int i = 0; i < 16; i++) begin
            do_push(8'(10 + i));
            chk("fill_count", count, i);
            chk("fill_afull", almost_full, (i >= 14) ? 1 : 0);
            chk("fill_full", full, 0);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("full_flag", full, 1);
        chk("full_count", count, 16);
        chk("full_afull", almost_full, 1);

        // Push while full is dropped
        drive(1'b1, 8'hEE, 1'b0);
        chk("ovf_we", we, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", overflow, 0);

        // Drain, expecting 10..25 in order
        for (int i = 0; i < 16; i++) begin
            do_pop(8'(10 + i));
            chk("drain_count", count, 16 - i);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_count0", count, 0);

        // Pop while empty is dropped
        drive(1'b0, 8'h00, 1'b1);
        chk("udf_re", re, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("udf_pulse", underflow, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("udf_clear", underflow, 0);

        // Simultaneous at count 0: push wins, underflow
        drive(1'b1, 8'd30, 1'b1);
        chk("sim0_we", we, 1);
        chk("sim0_re", re, 0);
        chk("sim0_wr_addr", wr_addr, 0);
        n_wr++;
        drive(1'b0, 8'h00, 1'b0);
        chk("sim0_count", count, 1);
        chk("sim0_udf", underflow, 1);
        for (int i = 31; i <= 34; i++) do_push(8'(i));
        drive(1'b0, 8'h00, 1'b0);
        chk("pre5_count", count, 5);

        // Simultaneous at count 5: both accepted, distinct addresses
        drive(1'b1, 8'd35, 1'b1);
        chk("sim5_we", we, 1);
        chk("sim5_re", re, 1);
        chk("sim5_wr_addr", wr_addr, 5);
        chk("sim5_re_addr", re_addr, 0);
        exp_q.push_back(8'd30);
        n_wr++; n_rd++;
        drive(1'b0, 8'h00, 1'b0);
        chk("sim5_count", count, 5);
        chk("sim5_flags", {overflow, underflow}, 0);

        // Fill to 16 with 36..46, then simultaneous at full
        for (int i = 36; i <= 46; i++) do_push(8'(i));
        drive(1'b1, 8'd99, 1'b1);
        chk("sim16_we", we, 0);
        chk("sim16_re", re, 1);
        chk("sim16_re_addr", re_addr, 1);
        exp_q.push_back(8'd31);
        n_rd++;
        drive(1'b0, 8'h00, 1'b0);
        chk("sim16_count", count, 15);
        chk("sim16_ovf", overflow, 1);
        for (int i = 32; i <= 46; i++) do_pop(8'(i));
        drive(1'b0, 8'h00, 1'b0);
        chk("sim_drain_empty", empty, 1);

        // Wrap test: alternating push/pop, addresses roll over 15 -> 0
        for (int i = 0; i < 40; i++) begin
            do_push(8'(i + 10));
            chk("wrap_full", full, 0);
            do_pop(8'(i + 10));
            chk("wrap_full", full, 0);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("wrap_empty", empty, 1);

        // Reset at count 9 while a pop is being accepted
        for (int i = 0; i < 9; i++) do_push(8'(50 + i));
        drive(1'b0, 8'h00, 1'b1);
        chk("rstmid_count", count, 9);
        chk("rstmid_re", re, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_count0", count, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_re_off", re, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("rstmid_dv", dout_valid, 0);
        rst = 1'b0;
        n_wr = 0; n_rd = 0;

        // Controller restarts cleanly from address 0
        do_push(8'd77);
        do_pop(8'd77);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("dout_hold", dout, 8'd77);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
`default_nettype wire
